// File: rtl/display_pkg.sv
// Shared constants for the display path: converter sizing, FSM encoding and
// the refresh interval agreed between the converter and the segment serialiser.
package display_pkg;

  localparam int BIN_W         = 14;
  localparam int DIGITS        = 4;
  localparam int MAX_VAL       = 9999;
  localparam int SEND_INTERVAL = 50000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit correction cell: digits of 5 or more get 3 added before the
// next shift, so the doubled value carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Correct the digit before it is doubled.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one bit per enabled
// clock, saturating to all nines when the input exceeds the displayable range.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [BIN_W:0]   MAX_CMP  = (BIN_W+1)'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t                 state_r;
  logic [CNT_W-1:0]       counter_r;
  logic [SR_W-1:0]        sr_r;
  logic                   sat_r;
  logic [4*DIGITS-1:0]    adj_s;
  logic [SR_W-1:0]        next_sr_s;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
        .digit    (sr_r[BIN_W + 4*g +: 4]),
        .adjusted (adj_s[4*g +: 4])
      );
    end
  endgenerate

  // One iteration: corrected digits above the remaining binary bits, doubled.
  always_comb begin
    next_sr_s = {adj_s, sr_r[BIN_W-1:0]} << 1;
  end

  // FSM, iteration counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= '0;
      sr_r      <= '0;
      sat_r     <= 1'b0;
      bcd_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // done is a single-clock pulse even when enable drops right after it
      done <= 1'b0;
      if (enable) begin
        case (state_r)
          IDLE: begin
            if (start) begin
              sr_r      <= {{(4*DIGITS){1'b0}}, bin_in};
              counter_r <= '0;
              sat_r     <= ({1'b0, bin_in} > MAX_CMP);
              busy      <= 1'b1;
              state_r   <= SHIFT;
            end else begin
              state_r   <= IDLE;
            end
          end
          SHIFT: begin
            sr_r      <= next_sr_s;
            counter_r <= counter_r + 1'b1;
            if (counter_r == LAST_CNT) begin
              bcd_out  <= sat_r ? {DIGITS{4'h9}} : next_sr_s[SR_W-1:BIN_W];
              overflow <= sat_r;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_r  <= IDLE;
            end else begin
              state_r  <= SHIFT;
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected results are queued at start and
// checked by a monitor on every done pulse; timing checks run inline.
module tb_bin2bcd_seq;
  import display_pkg::*;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic [15:0]       bcd_out;
  logic              busy, done, overflow;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   spurious = 0;
  exp_t sb[$];

  bin2bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each done pulse pops and checks one queued result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_bcd", {16'h0, bcd_out}, {16'h0, e.bcd});
        check("sb_ovf", {31'h0, overflow}, {31'h0, e.ovf});
      end else begin
        spurious++;
      end
    end
  end

  task automatic conv(input logic [BIN_W-1:0] val, input logic [15:0] exp_bcd,
                      input logic exp_ovf, input int exp_lat,
                      input int freeze_at, input int freeze_len,
                      input int pulse_a, input int pulse_b);
    int          cycles;
    int          base;
    logic        busy_ok;
    logic        stable_ok;
    logic [15:0] held;
    exp_t        e;
    @(negedge clk);
    e.bcd = exp_bcd;
    e.ovf = exp_ovf;
    sb.push_back(e);
    base   = done_cnt;
    held   = bcd_out;
    bin_in = val;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'h1);
    cycles    = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (done !== 1'b1 && cycles < 60) begin
      if (cycles == freeze_at) enable = 1'b0;
      if (cycles == freeze_at + freeze_len) enable = 1'b1;
      start = (cycles == pulse_a || cycles == pulse_b);
      @(posedge clk);
      #1;
      cycles++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd_out !== held) stable_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", cycles, exp_lat);
    check("busy_held", {31'h0, busy_ok}, 32'h1);
    check("bcd_stable", {31'h0, stable_ok}, 32'h1);
    check("busy_at_done", {31'h0, busy}, 32'h0);
    // done must clear on the next edge even with enable low
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("done_pulse", {31'h0, done}, 32'h0);
    check("done_count", done_cnt, base + 1);
    enable = 1'b1;
  endtask

  initial begin
    int base;
    #12;
    check("rst_bcd", {16'h0, bcd_out}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    conv(14'd0,     16'h0000, 1'b0, 14, -1, 0, -1, -1);
    conv(14'd1234,  16'h1234, 1'b0, 14, -1, 0, -1, -1);
    conv(14'd9999,  16'h9999, 1'b0, 14, -1, 0, -1, -1);
    conv(14'd7,     16'h0007, 1'b0, 14, -1, 0, -1, -1);
    conv(14'd10000, 16'h9999, 1'b1, 14, -1, 0, -1, -1);
    conv(14'd16383, 16'h9999, 1'b1, 14, -1, 0, -1, -1);
    conv(14'd42,    16'h0042, 1'b0, 14, -1, 0, -1, -1);
    // start pulses while busy are dropped
    conv(14'd2468,  16'h2468, 1'b0, 14, -1, 0, 3, 9);
    // five disabled clocks stretch the latency
    conv(14'd4321,  16'h4321, 1'b0, 19, 5, 5, -1, -1);
    conv(14'd555,   16'h0555, 1'b0, 14, -1, 0, -1, -1);

    // asynchronous reset mid-conversion aborts it and clears the result
    @(negedge clk);
    bin_in = 14'd1111;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_bcd", {16'h0, bcd_out}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    base  = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, base);
    conv(14'd8080,  16'h8080, 1'b0, 14, -1, 0, -1, -1);

    check("spurious_done", spurious, 0);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
